// File: rtl/acl_fifo_pkg.sv
// Shared types and defaults for the ACL egress store-and-forward buffer.
package acl_fifo_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 9;

  // Stored word: bit DATA_W carries the frame-last flag.
  typedef logic [DATA_W_DEF:0] word_t;

  typedef enum logic [0:0] {StAccept, StWaitVerdict} wr_state_t;
  typedef enum logic [0:0] {StIdle, StSend} rd_state_t;

endpackage

// File: rtl/acl_sdp_ram.sv
// Simple dual-port RAM with registered read; maps onto block RAM.
module acl_sdp_ram #(
  parameter int unsigned WIDTH  = 33,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port; rdata holds its value while re is low, which the reader relies on.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/acl_tx_fifo.sv
// Egress store-and-forward buffer: holds each frame until a pass/drop verdict,
// replays passed frames on an AXI-Stream master, rewinds over dropped ones.
module acl_tx_fifo
  import acl_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_last,
  output logic              o_wr_ready,
  input  logic              i_frame_pass,
  input  logic              i_frame_drop,
  output logic              o_txd_tvalid,
  output logic [DATA_W-1:0] o_txd_tdata,
  output logic              o_txd_tlast,
  input  logic              i_txd_tready,
  output logic [ADDR_W:0]   o_wr_cnt,
  output logic [ADDR_W:0]   o_frame_cnt,
  output logic              o_ovf_err
);

  localparam logic [ADDR_W:0] Depth = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] One   = {{ADDR_W{1'b0}}, 1'b1};

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] start_ptr_q, start_ptr_d;  // first word of the uncommitted frame
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;        // next word to fetch from RAM
  logic [ADDR_W:0] frame_cnt_q, frame_cnt_d;
  logic            err_q, err_d;
  logic            ovf_q, ovf_d;
  logic            rdy_en_q;
  logic            pend_q, pend_d;            // RAM read register holds an unconsumed word
  logic            tvalid_q, tvalid_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic            tlast_q, tlast_d;

  logic [ADDR_W:0] wr_cnt;
  logic            full, wr_ready, wr_en, commit;
  logic            hs, last_hs, load_out, slot_free, avail, fetch;
  logic [DATA_W:0] ram_rdata;

  assign wr_cnt   = wr_ptr_q - rd_ptr_q;
  assign full     = (wr_cnt == Depth);
  assign wr_ready = rdy_en_q && (wr_state_q == StAccept) && !full;
  assign wr_en    = i_wr_valid && wr_ready;

  assign hs        = tvalid_q && i_txd_tready;
  assign last_hs   = hs && tlast_q;
  assign load_out  = pend_q && (!tvalid_q || i_txd_tready);
  assign slot_free = !pend_q || load_out;
  assign avail     = (rd_ptr_q != start_ptr_q);

  acl_sdp_ram #(
    .WIDTH (DATA_W + 1),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr_q[ADDR_W-1:0]),
    .wdata({i_wr_last, i_wr_data}),
    .re   (fetch),
    .raddr(rd_ptr_q[ADDR_W-1:0]),
    .rdata(ram_rdata)
  );

  // Write FSM: accept words, then resolve the pending frame on its verdict.
  always_comb begin
    wr_state_d  = wr_state_q;
    wr_ptr_d    = wr_ptr_q;
    start_ptr_d = start_ptr_q;
    err_d       = err_q;
    ovf_d       = 1'b0;
    commit      = 1'b0;
    unique case (wr_state_q)
      StAccept: begin
        if (wr_en) begin
          wr_ptr_d = wr_ptr_q + One;
          if (i_wr_last) wr_state_d = StWaitVerdict;
        end else if (i_wr_valid && full && rdy_en_q) begin
          // Word lost; a lost last word still closes the frame so it can be rejected.
          err_d = 1'b1;
          if (i_wr_last) wr_state_d = StWaitVerdict;
        end
      end
      StWaitVerdict: begin
        if (i_frame_drop || (i_frame_pass && err_q)) begin
          wr_ptr_d   = start_ptr_q;
          ovf_d      = err_q;
          err_d      = 1'b0;
          wr_state_d = StAccept;
        end else if (i_frame_pass) begin
          start_ptr_d = wr_ptr_q;
          commit      = 1'b1;
          wr_state_d  = StAccept;
        end
      end
      default: wr_state_d = StAccept;
    endcase
  end

  // Committed-frame count; commit and final handshake in one cycle cancel out.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (commit)  frame_cnt_d = frame_cnt_d + One;
    if (last_hs) frame_cnt_d = frame_cnt_d - One;
  end

  // Read FSM: fetch committed words and keep the output register topped up.
  always_comb begin
    rd_state_d = rd_state_q;
    fetch      = 1'b0;
    unique case (rd_state_q)
      StIdle: begin
        if (frame_cnt_q != '0 && avail && slot_free) begin
          fetch      = 1'b1;
          rd_state_d = StSend;
        end
      end
      StSend: begin
        fetch = avail && slot_free;
        if (last_hs && frame_cnt_d == '0) rd_state_d = StIdle;
      end
      default: rd_state_d = StIdle;
    endcase
  end

  // Output register and RAM-pending bookkeeping.
  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    pend_d   = pend_q;
    rd_ptr_d = rd_ptr_q;
    if (load_out) begin
      tvalid_d = 1'b1;
      tdata_d  = ram_rdata[DATA_W-1:0];
      tlast_d  = ram_rdata[DATA_W];
      pend_d   = 1'b0;
    end else if (hs) begin
      tvalid_d = 1'b0;
    end
    if (fetch) begin
      pend_d   = 1'b1;
      rd_ptr_d = rd_ptr_q + One;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state_q  <= StAccept;
      rd_state_q  <= StIdle;
      wr_ptr_q    <= '0;
      start_ptr_q <= '0;
      rd_ptr_q    <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      rdy_en_q    <= 1'b0;
      pend_q      <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      rd_state_q  <= rd_state_d;
      wr_ptr_q    <= wr_ptr_d;
      start_ptr_q <= start_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      rdy_en_q    <= 1'b1;
      pend_q      <= pend_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
    end
  end

  assign o_wr_ready   = wr_ready;
  assign o_txd_tvalid = tvalid_q;
  assign o_txd_tdata  = tdata_q;
  assign o_txd_tlast  = tlast_q;
  assign o_wr_cnt     = wr_cnt;
  assign o_frame_cnt  = frame_cnt_q;
  assign o_ovf_err    = ovf_q;

endmodule

// File: tb/tb_acl_tx_fifo.sv
// Self-checking bench for acl_tx_fifo: scoreboard queue filled on pass verdicts,
// drained by a negedge monitor on every transmit handshake.
module tb_acl_tx_fifo;
  import acl_fifo_pkg::*;

  localparam int DW = 32;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_wr_valid = 1'b0;
  logic [DW-1:0] i_wr_data = '0;
  logic          i_wr_last = 1'b0;
  logic          o_wr_ready;
  logic          i_frame_pass = 1'b0;
  logic          i_frame_drop = 1'b0;
  logic          o_txd_tvalid;
  logic [DW-1:0] o_txd_tdata;
  logic          o_txd_tlast;
  logic          i_txd_tready = 1'b1;
  logic [AW:0]   o_wr_cnt;
  logic [AW:0]   o_frame_cnt;
  logic          o_ovf_err;

  int    n_checks = 0;
  int    n_fail = 0;
  word_t exp_q[$];
  word_t pend_frame[$];
  logic  stall_mode = 1'b0;
  logic  [3:0] stall_pat = 4'b1001;
  int    stall_idx = 0;
  logic  stall_prev = 1'b0;
  logic  [DW-1:0] prev_data;
  logic  prev_last;
  word_t got;
  word_t exp;

  acl_tx_fifo #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_wr_valid  (i_wr_valid),
    .i_wr_data   (i_wr_data),
    .i_wr_last   (i_wr_last),
    .o_wr_ready  (o_wr_ready),
    .i_frame_pass(i_frame_pass),
    .i_frame_drop(i_frame_drop),
    .o_txd_tvalid(o_txd_tvalid),
    .o_txd_tdata (o_txd_tdata),
    .o_txd_tlast (o_txd_tlast),
    .i_txd_tready(i_txd_tready),
    .o_wr_cnt    (o_wr_cnt),
    .o_frame_cnt (o_frame_cnt),
    .o_ovf_err   (o_ovf_err)
  );

  always #5 clk = ~clk;

  // Ready pattern 1,0,0,1,... while stalling is enabled.
  always @(posedge clk) begin
    if (stall_mode) begin
      #1;
      i_txd_tready = stall_pat[stall_idx % 4];
      stall_idx++;
    end
  end

  // Scoreboard monitor: stability under stall and in-order data on handshakes.
  always @(negedge clk) begin
    if (rst) begin
      if (stall_prev) begin
        n_checks++;
        if (o_txd_tvalid !== 1'b1 || o_txd_tdata !== prev_data || o_txd_tlast !== prev_last) begin
          n_fail++;
          $display("FAIL hold_stable: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                   o_txd_tvalid, o_txd_tdata, o_txd_tlast, prev_data, prev_last);
        end
      end
      stall_prev = o_txd_tvalid && !i_txd_tready;
      prev_data  = o_txd_tdata;
      prev_last  = o_txd_tlast;
      if (o_txd_tvalid && i_txd_tready) begin
        n_checks++;
        got = {o_txd_tlast, o_txd_tdata};
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got %h, want no beat", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL tx_data: got %h, want %h", got, exp);
          end
        end
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic send_word(input logic [DW-1:0] d, input logic last);
    int tries = 0;
    i_wr_valid = 1'b1;
    i_wr_data  = d;
    i_wr_last  = last;
    while (!o_wr_ready && tries < 100) begin
      @(posedge clk); #1;
      tries++;
    end
    if (!o_wr_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL wr_ready_timeout: got ready=0, want 1");
    end
    @(posedge clk); #1;
    i_wr_valid = 1'b0;
    i_wr_last  = 1'b0;
    pend_frame.push_back({last, d});
  endtask

  task automatic send_frame(input logic [DW-1:0] base, input int n);
    pend_frame.delete();
    for (int i = 0; i < n; i++) send_word(base + DW'(i), (i == n - 1));
  endtask

  // Verdict pulse; returns 1 ns after the edge that sampled it.
  task automatic verdict(input logic pass, input logic drop);
    i_frame_pass = pass;
    i_frame_drop = drop;
    if (pass && !drop) begin
      foreach (pend_frame[i]) exp_q.push_back(pend_frame[i]);
    end
    pend_frame.delete();
    @(posedge clk); #1;
    i_frame_pass = 1'b0;
    i_frame_drop = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d beats left, want 0", name, exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (o_frame_cnt !== '0 || o_txd_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: got frame_cnt=%0d tvalid=%b, want 0 0", name, o_frame_cnt,
               o_txd_tvalid);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (o_wr_ready !== 1'b0 || o_txd_tvalid !== 1'b0 || o_wr_cnt !== '0 ||
        o_frame_cnt !== '0 || o_ovf_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b v=%b wc=%0d fc=%0d ovf=%b, want 0 0 0 0 0",
               o_wr_ready, o_txd_tvalid, o_wr_cnt, o_frame_cnt, o_ovf_err);
    end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (o_wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b, want 1", o_wr_ready);
    end
  endtask

  task automatic test_pass_latency();
    i_txd_tready = 1'b1;
    send_frame(32'hA0, 4);
    n_checks++;
    if (o_wr_cnt !== 10'd4 || o_wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL a_wait_verdict: got wr_cnt=%0d rdy=%b, want 4 0", o_wr_cnt, o_wr_ready);
    end
    verdict(1'b1, 1'b0);
    n_checks++;
    if (o_frame_cnt !== 10'd1 || o_txd_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL a_commit: got fc=%0d v=%b, want 1 0", o_frame_cnt, o_txd_tvalid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (o_txd_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL a_latency_early: got tvalid=%b at N+1, want 0", o_txd_tvalid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (o_txd_tvalid !== 1'b1 || o_txd_tdata !== 32'hA0) begin
      n_fail++;
      $display("FAIL a_latency: got v=%b d=%h at N+2, want 1 a0", o_txd_tvalid, o_txd_tdata);
    end
    drain("a");
  endtask

  task automatic test_drop();
    send_word(32'hB0, 1'b0);
    // Verdict while accepting must be ignored.
    i_frame_pass = 1'b1;
    @(posedge clk); #1;
    i_frame_pass = 1'b0;
    n_checks++;
    if (o_frame_cnt !== '0 || o_wr_cnt !== 10'd1 || o_wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b_ignore_verdict: got fc=%0d wc=%0d rdy=%b, want 0 1 1", o_frame_cnt,
               o_wr_cnt, o_wr_ready);
    end
    send_word(32'hB1, 1'b0);
    send_word(32'hB2, 1'b1);
    n_checks++;
    if (o_wr_cnt !== 10'd3) begin
      n_fail++;
      $display("FAIL b_wr_cnt: got %0d, want 3", o_wr_cnt);
    end
    verdict(1'b0, 1'b1);
    n_checks++;
    if (o_wr_cnt !== '0 || o_frame_cnt !== '0 || o_wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b_drop: got wc=%0d fc=%0d rdy=%b, want 0 0 1", o_wr_cnt, o_frame_cnt,
               o_wr_ready);
    end
    send_frame(32'hC0, 2);
    verdict(1'b1, 1'b0);
    drain("c");
  endtask

  task automatic test_stall();
    stall_idx  = 0;
    stall_mode = 1'b1;
    send_frame(32'h5100, 3);
    verdict(1'b1, 1'b0);
    drain("stall");
    stall_mode = 1'b0;
    @(posedge clk); #1;
    i_txd_tready = 1'b1;
  endtask

  task automatic test_overflow();
    int beats = 0;
    i_txd_tready = 1'b1;
    pend_frame.delete();
    for (int i = 0; i < 512; i++) send_word(32'h1000 + DW'(i), 1'b0);
    n_checks++;
    if (o_wr_ready !== 1'b0 || o_wr_cnt !== 10'd512) begin
      n_fail++;
      $display("FAIL ovf_full: got rdy=%b wc=%0d, want 0 512", o_wr_ready, o_wr_cnt);
    end
    i_wr_valid = 1'b1;
    i_wr_data  = 32'hDEAD;
    @(posedge clk); #1;
    i_wr_last = 1'b1;
    @(posedge clk); #1;
    i_wr_valid = 1'b0;
    i_wr_last  = 1'b0;
    n_checks++;
    if (o_ovf_err !== 1'b0 || o_wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_before_verdict: got ovf=%b rdy=%b, want 0 0", o_ovf_err, o_wr_ready);
    end
    pend_frame.delete();
    i_frame_pass = 1'b1;
    @(posedge clk); #1;
    i_frame_pass = 1'b0;
    n_checks++;
    if (o_ovf_err !== 1'b1 || o_wr_cnt !== '0 || o_frame_cnt !== '0) begin
      n_fail++;
      $display("FAIL ovf_pulse: got ovf=%b wc=%0d fc=%0d, want 1 0 0", o_ovf_err, o_wr_cnt,
               o_frame_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (o_txd_tvalid) beats++;
    end
    n_checks++;
    if (o_ovf_err !== 1'b0 || beats != 0 || o_wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_after: got ovf=%b beats=%0d rdy=%b, want 0 0 1", o_ovf_err, beats,
               o_wr_ready);
    end
  endtask

  task automatic test_back_to_back();
    i_txd_tready = 1'b0;
    send_frame(32'hD0, 2);
    verdict(1'b1, 1'b0);
    send_frame(32'hE0, 2);
    verdict(1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (o_frame_cnt !== 10'd2 || o_txd_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: got fc=%0d v=%b, want 2 1", o_frame_cnt, o_txd_tvalid);
    end
    i_txd_tready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      n_checks++;
      if (o_txd_tvalid !== 1'b1 || o_txd_tlast !== logic'(b % 2 == 1)) begin
        n_fail++;
        $display("FAIL b2b_beat%0d: got v=%b l=%b, want 1 %b", b, o_txd_tvalid, o_txd_tlast,
                 logic'(b % 2 == 1));
      end
    end
    drain("b2b");
    send_frame(32'hF0, 2);
    verdict(1'b1, 1'b1);
    n_checks++;
    if (o_wr_cnt !== '0 || o_frame_cnt !== '0) begin
      n_fail++;
      $display("FAIL pass_drop: got wc=%0d fc=%0d, want 0 0", o_wr_cnt, o_frame_cnt);
    end
    repeat (5) @(posedge clk);
  endtask

  task automatic test_reset_midstream();
    int n = 0;
    i_txd_tready = 1'b1;
    send_frame(32'h700, 8);
    verdict(1'b1, 1'b0);
    while (!o_txd_tvalid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (o_txd_tvalid !== 1'b0 || o_wr_cnt !== '0 || o_frame_cnt !== '0 || o_wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b wc=%0d fc=%0d rdy=%b, want 0 0 0 0", o_txd_tvalid,
               o_wr_cnt, o_frame_cnt, o_wr_ready);
    end
    exp_q.delete();
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (o_wr_ready !== 1'b1 || o_txd_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_release: got rdy=%b v=%b, want 1 0", o_wr_ready, o_txd_tvalid);
    end
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (o_txd_tvalid !== 1'b0 || o_frame_cnt !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_flush: got v=%b fc=%0d, want 0 0", o_txd_tvalid, o_frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_pass_latency();
    test_drop();
    test_stall();
    test_overflow();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acl_tx_fifo.md
Name: acl_tx_fifo

Overview:
Egress store-and-forward buffer for the ACL datapath. It accepts 32-bit frame words from the filter stage and holds each frame until a pass/drop verdict arrives. Passed frames are replayed on an AXI-Stream transmit master toward the MAC TX. Dropped frames are discarded by rewinding the write pointer, so no dropped-frame data ever reaches the transmit port.

Parameters:
DATA_W, 32, word width; matches the receive-side stream width.
ADDR_W, 9, buffer address width; depth is 2**ADDR_W = 512 words.

Ports:
clk  in  1  single clock, 156.25 MHz (6.4 ns).
rst  in  1  asynchronous, active-low reset.
i_wr_valid  in  1  write word valid.
i_wr_data  in  DATA_W  write word.
i_wr_last  in  1  last word of the frame.
o_wr_ready  out  1  write side can accept a word this cycle.
i_frame_pass  in  1  one-cycle verdict pulse: commit the pending frame.
i_frame_drop  in  1  one-cycle verdict pulse: discard the pending frame.
o_txd_tvalid  out  1  AXI-S master valid.
o_txd_tdata  out  DATA_W  AXI-S master data.
o_txd_tlast  out  1  AXI-S master last.
i_txd_tready  in  1  AXI-S slave ready.
o_wr_cnt  out  ADDR_W+1  words occupied, including the uncommitted frame.
o_frame_cnt  out  ADDR_W+1  committed frames not yet fully sent.
o_ovf_err  out  1  one-cycle pulse: frame truncated by full buffer.

Behaviour:
- Reset (rst=0, asynchronous):
  - All pointers, counts, o_txd_* and o_ovf_err are 0; both FSMs return to their initial state.
  - o_wr_ready is 0 while rst is asserted and 1 from the first clock edge after release.
  - Reset mid-frame discards everything, committed frames included.
- Storage:
  - Dual-port RAM, DATA_W+1 bits wide; bit DATA_W stores last.
  - 1-cycle read latency.
  - Pointers are ADDR_W+1 bits; the MSB marks wrap. Full = 2**ADDR_W words occupied.
- Write FSM, state ACCEPT:
  - A word is written when i_wr_valid and o_wr_ready are both high.
  - o_wr_ready = ACCEPT and not full.
  - If i_wr_valid is high while full, the word is lost and the frame is marked errored. o_wr_ready stays low while full.
  - A write with i_wr_last=1 moves the FSM to WAIT_VERDICT.
- Write FSM, state WAIT_VERDICT:
  - o_wr_ready=0.
  - pass (frame not errored): the frame-start pointer advances to the write pointer, o_frame_cnt increments, and the FSM returns to ACCEPT.
  - drop, or pass on an errored frame: the write pointer rewinds to frame start, o_wr_cnt drops back, and the FSM returns to ACCEPT. An errored frame also pulses o_ovf_err in the verdict cycle.
  - pass and drop in the same cycle: drop wins.
- Verdicts in ACCEPT are ignored; they must not alter state.
- A full buffer with no last word deadlocks by design. The upstream stage must bound frame length to at most depth words (frames up to 1518 bytes = 380 words fit).
- Read FSM, state IDLE:
  - Waits for o_frame_cnt > 0.
  - Latency: a pass sampled at edge N gives o_txd_tvalid=1 after edge N+2 when the FSM is idle.
- Read FSM, state SEND:
  - The output register is refilled from RAM whenever it is empty or a handshake (tvalid & tready) occurs, so back-to-back words stream at 1 word/cycle with no bubbles.
  - o_txd_tdata and o_txd_tlast are held stable while tvalid=1 and tready=0.
  - On the tlast handshake, o_frame_cnt decrements. The FSM returns to IDLE, or continues directly into the next committed frame (no idle cycle required).
  - The read FSM never fetches beyond the committed frame-start pointer.
- Simultaneous events:
  - Commit and last-word handshake in the same cycle: o_frame_cnt is net unchanged.
  - Write and read in the same cycle: o_wr_cnt is net unchanged.
- o_wr_cnt = write pointer − read pointer, where the read pointer advances at RAM fetch.

Decomposition:
- Shared package acl_fifo_pkg holds:
  - DATA_W and ADDR_W defaults;
  - typedef word_t = logic [DATA_W:0] (data plus last);
  - enums wr_state_t {ACCEPT, WAIT_VERDICT} and rd_state_t {IDLE, SEND}.
- One sub-module, acl_sdp_ram: simple dual-port RAM, synchronous read, inferred BRAM. The FSMs and pointers stay in the top level.

Test Plan:
- 4-word frame 0xA0..0xA3 with pass, tready=1 → tvalid rises 2 cycles after pass; words A0..A3 appear on consecutive cycles; tlast on A3; o_frame_cnt 1→0.
- Frame 0xB0..0xB2 with drop, then 0xC0..0xC1 with pass → only C0,C1 are transmitted; o_wr_cnt returns to 0 after the drop cycle.
- 3-word frame, pass, tready toggling 1,0,0,1,... → each word is held stable while stalled; the sequence is complete and ordered.
- Write 512 words without last, then a 513th word, then last, then pass → o_wr_ready=0 when full; o_ovf_err pulses for one cycle; nothing is transmitted; o_wr_cnt=0.
- Two committed frames of 2 words each → 4 consecutive tvalid beats with tlast on beats 2 and 4; pass and drop together on a third frame → dropped.
- Assert rst=0 mid-transmission → o_txd_tvalid=0 immediately (asynchronously); counts are 0; o_wr_ready=1 on the first edge after release.
